// File: rtl/audio_clk_pkg.sv
// Shared types and default cycle budgets for the audio clock supervisor.
// Defaults assume a 50 MHz reference clock feeding the 12.288 MHz audio PLL.
package audio_clk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } sup_state_t;

   localparam int DEF_RST_PULSE_CYCLES    = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;  // 10 ms at 50 MHz
   localparam int DEF_MAX_RETRIES         = 3;
   localparam int DEF_CNT_W               = 20;

   localparam int LOSS_CNT_W = 8;
   localparam int RETRY_W    = 2;

   // Saturating increment for the lock-loss event counter.
   function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
      return (&v) ? v : v + LOSS_CNT_W'(1);
   endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for quasi-static level signals entering the clk domain.
// Each bit is synchronised independently; multi-bit buses must be gray-coded
// or otherwise tolerant of per-bit skew.
module bit_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Capture stage then resolve stage; both clear to 0 on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/audio_pll_supervisor.sv
// Audio PLL supervisor: pulses the PLL reset, waits for lock with a timeout,
// qualifies lock stability, then releases the audio-domain reset. Lock loss in
// RUN re-sequences the PLL; exhausted retries latch FAULT until clear_fault.
// All outputs are registered and decoded from the next state, so they move on
// the same edge as the state register.
module audio_pll_supervisor
   import audio_clk_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  clear_fault,
   input  logic                  pll_locked,
   output logic                  pll_rst,
   output logic                  audio_reset_n,
   output logic                  clk_ok,
   output logic                  fault,
   output logic [RETRY_W-1:0]    retry_count,
   output logic [LOSS_CNT_W-1:0] lock_loss_count,
   output sup_state_t            dbg_state
);

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

   sup_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;
   logic                  pll_rst_q, pll_rst_d;
   logic                  arst_n_q, arst_n_d;
   logic                  clk_ok_q, clk_ok_d;
   logic                  fault_q, fault_d;
   logic                  lock_s;

   bit_sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d_i   (pll_locked),
      .q_o   (lock_s)
   );

   // Next-state, retry and lock-loss bookkeeping; enable=0 overrides everything but FAULT.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;

      // A lock loss seen in RUN is counted even when enable drops on the same edge.
      if ((state_q == RUN) && !lock_s) begin
         loss_d = sat_inc(loss_q);
      end

      if ((state_q != FAULT) && !enable) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enable) state_d = PLL_RST;
            end
            PLL_RST: begin
               if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABLE;
               end else if (cnt_q == TO_LAST) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + RETRY_W'(1);
                     state_d = PLL_RST;
                  end else begin
                     state_d = FAULT;
                  end
               end
            end
            STABLE: begin
               // Any dip restarts qualification with a fresh lock timeout.
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = RUN;
                  retry_d = '0;
               end
            end
            RUN: begin
               if (!lock_s) state_d = PLL_RST;
            end
            FAULT: begin
               if (clear_fault) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Every return to IDLE starts a fresh sequence with a full retry budget.
      if (state_d == IDLE) retry_d = '0;
   end

   // Cycle counter restarts on every state change; it only matters in the timed states.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d != state_q) cnt_d = '0;
   end

   // Output decode from the next state so outputs register together with it.
   always_comb begin
      pll_rst_d = (state_d == IDLE) || (state_d == PLL_RST) || (state_d == FAULT);
      arst_n_d  = (state_d == RUN);
      clk_ok_d  = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         retry_q   <= '0;
         loss_q    <= '0;
         pll_rst_q <= 1'b1;
         arst_n_q  <= 1'b0;
         clk_ok_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         loss_q    <= loss_d;
         pll_rst_q <= pll_rst_d;
         arst_n_q  <= arst_n_d;
         clk_ok_q  <= clk_ok_d;
         fault_q   <= fault_d;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign audio_reset_n   = arst_n_q;
   assign clk_ok          = clk_ok_q;
   assign fault           = fault_q;
   assign retry_count     = retry_q;
   assign lock_loss_count = loss_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Bench for audio_pll_supervisor with small cycle budgets.
// A phase/countdown model predicts every output each cycle; directed scenarios
// add hand-computed timing checks (bring-up, timeout/fault, glitch, lock loss,
// saturation, enable drop, asynchronous reset).
module tb_audio_pll_supervisor;
   import audio_clk_pkg::*;

   localparam int P_RST  = 4;
   localparam int P_STB  = 8;
   localparam int P_TO   = 32;
   localparam int P_MAXR = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   logic enable;
   logic clear_fault;
   logic pll_locked;

   logic                  pll_rst;
   logic                  audio_reset_n;
   logic                  clk_ok;
   logic                  fault;
   logic [RETRY_W-1:0]    retry_count;
   logic [LOSS_CNT_W-1:0] lock_loss_count;
   sup_state_t            dbg_state;

   always #5 clk = ~clk;

   audio_pll_supervisor #(
      .RST_PULSE_CYCLES    (P_RST),
      .LOCK_STABLE_CYCLES  (P_STB),
      .LOCK_TIMEOUT_CYCLES (P_TO),
      .MAX_RETRIES         (P_MAXR),
      .CNT_W               (20)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .clear_fault     (clear_fault),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .audio_reset_n   (audio_reset_n),
      .clk_ok          (clk_ok),
      .fault           (fault),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count),
      .dbg_state       (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases: off (pll held), pulse (timed reset pulse), hunt (waiting for lock),
   // qual (lock must hold), good (audio clock usable), dead (latched fault).
   typedef enum int {M_OFF, M_PULSE, M_HUNT, M_QUAL, M_GOOD, M_DEAD} mphase_t;

   mphase_t m_phase;
   int      m_left;
   int      m_retries;
   int      m_losses;
   bit      m_hist[$];   // [0] = lock sampled last edge, [1] = two edges ago

   task automatic model_reset();
      m_phase   = M_OFF;
      m_left    = 0;
      m_retries = 0;
      m_losses  = 0;
      m_hist    = '{1'b0, 1'b0};
   endtask

   task automatic model_update();
      bit ls;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ls = m_hist[1];
      m_hist.push_front(pll_locked);
      void'(m_hist.pop_back());

      if (m_phase != M_DEAD && !enable) begin
         if (m_phase == M_GOOD && !ls) m_losses = (m_losses < 255) ? m_losses + 1 : 255;
         m_phase   = M_OFF;
         m_retries = 0;
      end else begin
         case (m_phase)
            M_OFF: if (enable) begin m_phase = M_PULSE; m_left = P_RST; end
            M_PULSE: begin
               m_left--;
               if (m_left == 0) begin m_phase = M_HUNT; m_left = P_TO; end
            end
            M_HUNT: begin
               if (ls) begin
                  m_phase = M_QUAL; m_left = P_STB;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     if (m_retries < P_MAXR) begin
                        m_retries++; m_phase = M_PULSE; m_left = P_RST;
                     end else begin
                        m_phase = M_DEAD;
                     end
                  end
               end
            end
            M_QUAL: begin
               if (!ls) begin
                  m_phase = M_HUNT; m_left = P_TO;
               end else begin
                  m_left--;
                  if (m_left == 0) begin m_phase = M_GOOD; m_retries = 0; end
               end
            end
            M_GOOD: begin
               if (!ls) begin
                  m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                  m_phase  = M_PULSE; m_left = P_RST;
               end
            end
            M_DEAD: if (clear_fault) begin m_phase = M_OFF; m_retries = 0; end
            default: m_phase = M_OFF;
         endcase
      end
   endtask

   // Per-cycle compare of every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("pll_rst", pll_rst, int'(m_phase == M_OFF || m_phase == M_PULSE || m_phase == M_DEAD));
         check("audio_reset_n", audio_reset_n, int'(m_phase == M_GOOD));
         check("clk_ok", clk_ok, int'(m_phase == M_GOOD));
         check("fault", fault, int'(m_phase == M_DEAD));
         check("retry_count", retry_count, m_retries);
         check("lock_loss_count", lock_loss_count, m_losses);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_update();
         @(negedge clk);
      end
   endtask

   task automatic wait_clk_ok(input string name, input int budget);
      int n = 0;
      while (clk_ok !== 1'b1 && n < budget) begin
         step(1);
         n++;
      end
      check(name, clk_ok, 1);
   endtask

   // Asserts reset mid-cycle and checks that outputs fall back with no clock edge.
   task automatic pulse_reset(input string tag);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check({tag, "_pll_rst"}, pll_rst, 1);
      check({tag, "_audio_reset_n"}, audio_reset_n, 0);
      check({tag, "_clk_ok"}, clk_ok, 0);
      check({tag, "_fault"}, fault, 0);
      check({tag, "_retry"}, retry_count, 0);
      check({tag, "_loss"}, lock_loss_count, 0);
      step(2);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset_n     = 1'b1;
      enable      = 1'b0;
      clear_fault = 1'b0;
      pll_locked  = 1'b0;
      model_reset();

      // Power-on: reset asserted before the first clock edge.
      pulse_reset("por");
      chk_en = 1'b1;

      // 1. Normal bring-up.
      enable = 1'b1;
      step(4);
      check("t1_pulse_hi", pll_rst, 1);
      step(1);
      check("t1_pulse_lo", pll_rst, 0);
      step(10);
      pll_locked = 1'b1;
      // Two synchroniser edges, one edge into STABLE, eight qualification cycles.
      step(10);
      check("t1_clk_ok_early", clk_ok, 0);
      step(1);
      check("t1_clk_ok", clk_ok, 1);
      check("t1_audio_reset_n", audio_reset_n, 1);
      check("t1_retry", retry_count, 0);

      // clear_fault outside FAULT does nothing.
      clear_fault = 1'b1;
      step(1);
      clear_fault = 1'b0;
      check("cf_ignored", clk_ok, 1);

      // 4. Lock loss in RUN.
      pll_locked = 1'b0;
      step(2);
      check("t4_still_ok", clk_ok, 1);
      step(1);
      check("t4_clk_ok_drop", clk_ok, 0);
      check("t4_arst_drop", audio_reset_n, 0);
      check("t4_loss", lock_loss_count, 1);
      check("t4_pulse_start", pll_rst, 1);
      step(3);
      check("t4_pulse_hi", pll_rst, 1);
      step(1);
      check("t4_pulse_lo", pll_rst, 0);
      pll_locked = 1'b1;
      wait_clk_ok("t4_recover", 40);

      // 3. One-cycle lock glitch at stable cycle 5.
      enable     = 1'b0;
      pll_locked = 1'b0;
      step(1);
      enable = 1'b1;
      step(5);
      pll_locked = 1'b1;
      step(8);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(10);
      check("t3_no_early_run", clk_ok, 0);
      step(1);
      check("t3_clk_ok", clk_ok, 1);

      // 2. Lock never asserts: three attempts then FAULT.
      enable     = 1'b0;
      pll_locked = 1'b0;
      step(3);
      enable = 1'b1;
      step(108);
      check("t2_no_fault_yet", fault, 0);
      check("t2_retry_2", retry_count, 2);
      step(1);
      check("t2_fault", fault, 1);
      check("t2_pll_rst", pll_rst, 1);
      check("t2_retry_fault", retry_count, 2);
      enable = 1'b0;
      step(2);
      check("t2_enable_ignored", fault, 1);
      clear_fault = 1'b1;
      step(1);
      clear_fault = 1'b0;
      check("t2_cleared", fault, 0);
      check("t2_idle_pll_rst", pll_rst, 1);
      check("t2_retry_clr", retry_count, 0);

      // 5. Lock-loss counter saturation.
      enable     = 1'b1;
      pll_locked = 1'b1;
      wait_clk_ok("t5_up", 60);
      for (int i = 0; i < 260; i++) begin
         pll_locked = 1'b0;
         step(3);
         pll_locked = 1'b1;
         wait_clk_ok("t5_recover", 60);
      end
      check("t5_saturated", lock_loss_count, 255);

      // 6a. enable dropped mid-WAIT_LOCK.
      enable = 1'b0;
      step(1);
      pll_locked = 1'b0;
      enable     = 1'b1;
      step(6);
      check("t6_in_wait", pll_rst, 0);
      enable = 1'b0;
      step(1);
      check("t6_idle_pll_rst", pll_rst, 1);
      check("t6_idle_clk_ok", clk_ok, 0);

      // 6b. Asynchronous reset mid-RUN.
      enable     = 1'b1;
      pll_locked = 1'b1;
      wait_clk_ok("t6_up", 60);
      step(2);
      pulse_reset("t6_rst");
      wait_clk_ok("t6_reup", 60);

      // Lock loss and enable drop on the same edge: IDLE, loss still counted.
      pll_locked = 1'b0;
      step(2);
      enable = 1'b0;
      step(1);
      check("sim_loss", lock_loss_count, 1);
      check("sim_pll_rst", pll_rst, 1);
      check("sim_clk_ok", clk_ok, 0);
      step(3);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
